// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: round-robin sharing of one block-RAM port among N
// valid/ready requesters. It tracks the RAM read latency (1 or 2 cycles) and
// steers each read result back to the requester that issued it.
module bram_port_arbiter #(
    parameter int N       = 4,
    parameter int DW      = 32,
    parameter int AW      = 10,
    parameter int LATENCY = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [N-1:0]    i_req_valid,
    output logic [N-1:0]    o_req_ready,
    input  logic [N-1:0]    i_req_write,
    input  logic [N*AW-1:0] i_req_addr,
    input  logic [N*DW-1:0] i_req_data,
    output logic [N-1:0]    o_rsp_valid,
    output logic [DW-1:0]   o_rsp_data,
    output logic            o_bram_en,
    output logic            o_bram_we,
    output logic [AW-1:0]   o_bram_addr,
    output logic [DW-1:0]   o_bram_din,
    input  logic [DW-1:0]   i_bram_dout,
    output logic            o_bram_regce,
    output logic            o_bram_rst
);

    localparam int IDW = (N > 1) ? $clog2(N) : 1;

    generate
        if ((LATENCY != 1) && (LATENCY != 2)) begin : g_bad_latency
            $error("bram_port_arbiter: LATENCY must be 1 or 2");
        end
    endgenerate

    logic [2:0]     r_ptr;
    logic           w_grant_any;
    logic [IDW-1:0] w_grant_id;
    logic [3:0]     w_ptr_next;
    logic           w_xfer_rd;

    // Response tracking pipeline: one {valid, id} entry per cycle of RAM latency.
    logic           r_pipe_vld [LATENCY];
    logic [IDW-1:0] r_pipe_id  [LATENCY];

    // Round-robin search: first valid requester at or after the pointer.
    // Walking the offsets downward lets the smallest offset win.
    always_comb begin : p_grant
        logic [3:0] idx;
        w_grant_any = 1'b0;
        w_grant_id  = '0;
        idx         = 4'd0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = 4'(r_ptr) + 4'(k);
            if (idx >= 4'(N)) begin
                idx = idx - 4'(N);
            end else begin
                idx = idx;
            end
            if (i_req_valid[IDW'(idx)]) begin
                w_grant_any = 1'b1;
                w_grant_id  = IDW'(idx);
            end else begin
                w_grant_any = w_grant_any;
            end
        end
        if (i_rst) begin
            w_grant_any = 1'b0;
        end else begin
            w_grant_any = w_grant_any;
        end
    end

    // Pointer successor: one past the granted requester, wrapping at N.
    always_comb begin
        w_ptr_next = 4'(w_grant_id) + 4'd1;
        if (w_ptr_next >= 4'(N)) begin
            w_ptr_next = 4'd0;
        end else begin
            w_ptr_next = w_ptr_next;
        end
    end

    assign w_xfer_rd = w_grant_any & ~i_req_write[w_grant_id];

    // Round-robin pointer; moves only when a transfer happens.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= 3'd0;
        end else if (w_grant_any) begin
            r_ptr <= w_ptr_next[2:0];
        end else begin
            r_ptr <= r_ptr;
        end
    end

    // Command path: grant strobe and RAM pins driven from the granted slice.
    always_comb begin
        o_req_ready = '0;
        o_bram_en   = 1'b0;
        o_bram_we   = 1'b0;
        o_bram_addr = '0;
        o_bram_din  = '0;
        if (w_grant_any) begin
            o_req_ready[w_grant_id] = 1'b1;
            o_bram_en               = 1'b1;
            o_bram_we               = i_req_write[w_grant_id];
            o_bram_addr             = i_req_addr[int'(w_grant_id)*AW +: AW];
            o_bram_din              = i_req_data[int'(w_grant_id)*DW +: DW];
        end else begin
            o_bram_en = 1'b0;
        end
    end

    // Latency shift register; reset drops every read still in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_pipe_vld[i] <= 1'b0;
                r_pipe_id[i]  <= '0;
            end
        end else begin
            r_pipe_vld[0] <= w_xfer_rd;
            r_pipe_id[0]  <= w_grant_id;
            for (int i = 1; i < LATENCY; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_id[i]  <= r_pipe_id[i-1];
            end
        end
    end

    // Response steering: tail entry selects which requester sees the RAM data.
    always_comb begin
        o_rsp_valid = '0;
        o_rsp_data  = '0;
        if (r_pipe_vld[LATENCY-1] && !i_rst) begin
            o_rsp_valid[r_pipe_id[LATENCY-1]] = 1'b1;
            o_rsp_data                        = i_bram_dout;
        end else begin
            o_rsp_data = '0;
        end
    end

    assign o_bram_regce = 1'b1;
    assign o_bram_rst   = i_rst;

endmodule
